motor_cmd_sched: RTL and testbench

Two-requester command scheduler in front of one `motor_arbit` instance. It arbitrates move requests round-robin and latches the winner's motion parameters onto the motor's parameter bus. It then pulses `start`, supervises the move until `mt_success_int`, a non-zero `error_data`, a requester abort, or a watchdog timeout, and acknowledges the interrupt via `clear_mt_success`. Finally it returns a one-cycle `done` with a status code to the owning requester.

---
 rtl/motor_cmd_sched.sv | 201 ++++++++++++++++++++
 tb/tb_motor_cmd_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_sched.sv
// motor_cmd_sched: two-requester round-robin command scheduler in front of a
// single motor_arbit. Latches the winning requester's motion parameters,
// pulses start, supervises the move (interrupt / fault / abort / watchdog),
// acknowledges the motor interrupt and returns done+status to the owner.
module motor_cmd_sched #(
  parameter int unsigned BIT_A   = 19,
  parameter int unsigned BIT_V   = 19,
  parameter int unsigned BIT_S   = 19,
  parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  // requester side
  input  logic [1:0]           req,
  input  logic [1:0]           abort,
  input  logic [9:0]           req_mode,
  input  logic [2*BIT_S-1:0]   req_pos,
  input  logic [2*BIT_V-1:0]   req_vmax,
  input  logic [2*BIT_A-1:0]   req_acc,
  input  logic [31:0]          req_vstart,
  input  logic [1:0]           req_dir,
  output logic [1:0]           grant,
  output logic [1:0]           done,
  output logic [1:0]           status,
  output logic [4:0]           err_code,
  // motor parameter bus and control
  output logic [4:0]           move_mode,
  output logic [BIT_S-1:0]     position_set,
  output logic [BIT_V-1:0]     max_speed,
  output logic [BIT_A-1:0]     acc,
  output logic [15:0]          start_speed,
  output logic                 set_dir,
  output logic                 start,
  output logic                 stop,
  output logic                 clear_mt_success,
  input  logic                 mt_success_int,
  input  logic [4:0]           error_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_STOP,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERROR   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  state_t      state;
  state_t      next_state;
  logic        rr;           // favoured requester
  logic        owner;        // requester currently being served
  logic        winner;
  logic [31:0] wdog;
  logic [3:0]  clr_cnt;      // cycles spent in CLEAR, wraps to re-pulse the clear
  logic [1:0]  term_status;

  // Round-robin pick: favoured requester if it asks, otherwise the other one
  always_comb begin
    winner = req[rr] ? rr : ~rr;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and termination cause (error > success > abort > timeout)
  always_comb begin
    next_state  = state;
    term_status = ST_OK;
    case (state)
      S_IDLE: begin
        if (|req) begin
          next_state = S_LOAD;
        end
      end
      S_LOAD:  next_state = S_START;
      S_START: next_state = S_RUN;
      S_RUN: begin
        if (error_data != '0) begin
          term_status = ST_ERROR;
          next_state  = S_CLEAR;
        end else if (mt_success_int) begin
          term_status = ST_OK;
          next_state  = S_CLEAR;
        end else if (abort[owner]) begin
          term_status = ST_ABORT;
          next_state  = S_STOP;
        end else if (wdog == TIMEOUT - 32'd1) begin
          term_status = ST_TIMEOUT;
          next_state  = S_STOP;
        end
      end
      S_STOP: next_state = S_CLEAR;
      S_CLEAR: begin
        if (!mt_success_int) begin
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore control pulses decoded from the current state
  always_comb begin
    stop             = (state == S_STOP);
    clear_mt_success = (state == S_CLEAR) && (clr_cnt == '0);
    done             = (state == S_DONE) ? grant : '0;
  end

  // Owner selection, grant hold and round-robin pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= 1'b0;
      grant <= '0;
      rr    <= 1'b0;
    end else begin
      if (state == S_IDLE && (|req)) begin
        owner <= winner;
        grant <= winner ? 2'b10 : 2'b01;
      end else if (state == S_DONE) begin
        grant <= '0;
        rr    <= ~owner;
      end
    end
  end

  // Parameter bus: captured from the owner in LOAD, held until the next LOAD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_mode    <= '0;
      position_set <= '0;
      max_speed    <= '0;
      acc          <= '0;
      start_speed  <= '0;
      set_dir      <= 1'b0;
    end else if (state == S_LOAD) begin
      move_mode    <= owner ? req_mode[9:5]               : req_mode[4:0];
      position_set <= owner ? req_pos[2*BIT_S-1:BIT_S]    : req_pos[BIT_S-1:0];
      max_speed    <= owner ? req_vmax[2*BIT_V-1:BIT_V]   : req_vmax[BIT_V-1:0];
      acc          <= owner ? req_acc[2*BIT_A-1:BIT_A]    : req_acc[BIT_A-1:0];
      start_speed  <= owner ? req_vstart[31:16]           : req_vstart[15:0];
      set_dir      <= owner ? req_dir[1]                  : req_dir[0];
    end
  end

  // Start is registered off START so it lands one cycle after the bus is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start <= 1'b0;
    end else begin
      start <= (state == S_START);
    end
  end

  // Watchdog: cleared in LOAD, counts RUN cycles, saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == S_LOAD) begin
      wdog <= '0;
    end else if (state == S_RUN && wdog != '1) begin
      wdog <= wdog + 32'd1;
    end
  end

  // CLEAR dwell counter; wraps every 16 cycles so the clear is re-pulsed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + 4'd1;
    end else begin
      clr_cnt <= '0;
    end
  end

  // Status and motor error code captured on the cycle RUN terminates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status   <= '0;
      err_code <= '0;
    end else if (state == S_RUN && next_state != S_RUN) begin
      status   <= term_status;
      err_code <= error_data;
    end
  end

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Directed testbench for motor_cmd_sched with hand-computed expectations.
// Timeline convention: after "tick" the bench sits 1 time unit past a rising
// edge; outputs are sampled there and inputs changed there take effect at
// the next edge.
module tb_motor_cmd_sched;

  localparam int unsigned A = 20;  // acceleration 600000 needs 20 bits
  localparam int unsigned V = 19;
  localparam int unsigned S = 19;

  logic             clk;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       abort;
  logic [9:0]       req_mode;
  logic [2*S-1:0]   req_pos;
  logic [2*V-1:0]   req_vmax;
  logic [2*A-1:0]   req_acc;
  logic [31:0]      req_vstart;
  logic [1:0]       req_dir;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic [1:0]       status;
  logic [4:0]       err_code;
  logic [4:0]       move_mode;
  logic [S-1:0]     position_set;
  logic [V-1:0]     max_speed;
  logic [A-1:0]     acc;
  logic [15:0]      start_speed;
  logic             set_dir;
  logic             start;
  logic             stop;
  logic             clear_mt_success;
  logic             mt_success_int;
  logic [4:0]       error_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_stop   = 0;
  int n_clear  = 0;

  motor_cmd_sched #(
    .BIT_A   (A),
    .BIT_V   (V),
    .BIT_S   (S),
    .TIMEOUT (32'd1000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .abort            (abort),
    .req_mode         (req_mode),
    .req_pos          (req_pos),
    .req_vmax         (req_vmax),
    .req_acc          (req_acc),
    .req_vstart       (req_vstart),
    .req_dir          (req_dir),
    .grant            (grant),
    .done             (done),
    .status           (status),
    .err_code         (err_code),
    .move_mode        (move_mode),
    .position_set     (position_set),
    .max_speed        (max_speed),
    .acc              (acc),
    .start_speed      (start_speed),
    .set_dir          (set_dir),
    .start            (start),
    .stop             (stop),
    .clear_mt_success (clear_mt_success),
    .mt_success_int   (mt_success_int),
    .error_data       (error_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the active edge
  always @(posedge clk) begin
    if (start)            n_start <= n_start + 1;
    if (stop)             n_stop  <= n_stop + 1;
    if (clear_mt_success) n_clear <= n_clear + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req            = '0;
    abort          = '0;
    mt_success_int = 1'b0;
    error_data     = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Called in cycle 0 (request already driven); returns in the DONE cycle.
  task automatic fast_move(input logic [1:0] g, input string tag);
    tick();                                             // cycle 1: LOAD
    check({tag, "_grant"}, 64'(grant), 64'(g));
    tick();                                             // cycle 2
    tick();                                             // cycle 3: RUN entry
    check({tag, "_start"}, 64'(start), 64'd1);
    tick();                                             // cycle 4: RUN k
    mt_success_int = 1'b1;
    tick();                                             // k+1: CLEAR
    check({tag, "_clear"}, 64'(clear_mt_success), 64'd1);
    tick();                                             // k+2: interrupt falls
    mt_success_int = 1'b0;
    tick();                                             // k+3: DONE
    check({tag, "_done"}, 64'(done), 64'(g));
    check({tag, "_status"}, 64'(status), 64'd0);
  endtask

  int s0, p0, c0, cnt;

  initial begin
    req_mode   = {5'd7, 5'd2};
    req_pos    = {19'd5, 19'd18000};
    req_vmax   = {19'd9, 19'd24000};
    req_acc    = {20'd11, 20'd600000};
    req_vstart = {16'd3, 16'd100};
    req_dir    = 2'b01;

    // Reset state
    do_reset();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_pos", 64'(position_set), 64'd0);

    // Single move, requester 0
    s0 = n_start; c0 = n_clear;
    req = 2'b01;                                        // cycle 0
    tick();                                             // cycle 1
    check("single_grant", 64'(grant), 64'd1);
    check("single_start_c1", 64'(start), 64'd0);
    tick();                                             // cycle 2: bus valid
    check("single_pos", 64'(position_set), 64'd18000);
    check("single_vmax", 64'(max_speed), 64'd24000);
    check("single_acc", 64'(acc), 64'd600000);
    check("single_vstart", 64'(start_speed), 64'd100);
    check("single_mode", 64'(move_mode), 64'd2);
    check("single_dir", 64'(set_dir), 64'd1);
    check("single_start_c2", 64'(start), 64'd0);
    tick();                                             // cycle 3
    check("single_start_c3", 64'(start), 64'd1);
    tick();                                             // cycle 4
    check("single_start_c4", 64'(start), 64'd0);
    mt_success_int = 1'b1;
    tick();                                             // cycle 5
    check("single_clear", 64'(clear_mt_success), 64'd1);
    check("single_nodone", 64'(done), 64'd0);
    tick();                                             // cycle 6
    mt_success_int = 1'b0;
    tick();                                             // cycle 7
    check("single_done", 64'(done), 64'd1);
    check("single_status", 64'(status), 64'd0);
    req = 2'b00;
    tick();                                             // cycle 8: IDLE
    check("single_grant_drop", 64'(grant), 64'd0);
    check("single_done_drop", 64'(done), 64'd0);
    check("single_nstart", 64'(n_start - s0), 64'd1);
    check("single_nclear", 64'(n_clear - c0), 64'd1);

    // Contention: both request from reset
    do_reset();
    req = 2'b11;
    fast_move(2'b01, "cont0");
    tick();                                             // IDLE bubble
    check("cont_bubble", 64'(grant), 64'd0);
    fast_move(2'b10, "cont1");
    tick();
    check("cont_bubble2", 64'(grant), 64'd0);
    fast_move(2'b01, "cont2");
    req = 2'b00;
    tick();

    // Motor fault together with interrupt: error wins, no stop
    do_reset();
    p0 = n_stop;
    req = 2'b01;
    tick(); tick(); tick(); tick();                     // cycle 4
    mt_success_int = 1'b1;
    error_data     = 5'd5;
    tick();                                             // cycle 5: CLEAR
    check("fault_clear", 64'(clear_mt_success), 64'd1);
    check("fault_nostop", 64'(stop), 64'd0);
    error_data = 5'd0;
    tick();
    mt_success_int = 1'b0;
    tick();
    check("fault_done", 64'(done), 64'd1);
    check("fault_status", 64'(status), 64'd1);
    check("fault_err", 64'(err_code), 64'd5);
    req = 2'b00;
    tick();
    check("fault_nstop", 64'(n_stop - p0), 64'd0);

    // Abort from owner 200 cycles after start; non-owner abort ignored
    do_reset();
    p0 = n_stop; c0 = n_clear;
    req = 2'b01;
    tick(); tick(); tick();                             // cycle 3: start
    for (int i = 0; i < 200; i++) begin
      abort = (i == 100) ? 2'b10 : 2'b00;
      tick();
    end                                                 // cycle 203
    check("abort_still_running", 64'(n_stop - p0), 64'd0);
    check("abort_grant_held", 64'(grant), 64'd1);
    abort = 2'b01;
    tick();                                             // cycle 204: STOP
    abort = 2'b00;
    check("abort_stop", 64'(stop), 64'd1);
    tick();                                             // CLEAR
    check("abort_clear", 64'(clear_mt_success), 64'd1);
    check("abort_stop_once", 64'(stop), 64'd0);
    tick();                                             // DONE
    check("abort_done", 64'(done), 64'd1);
    check("abort_status", 64'(status), 64'd3);
    req = 2'b00;
    tick();
    check("abort_nstop", 64'(n_stop - p0), 64'd1);
    check("abort_nclear", 64'(n_clear - c0), 64'd1);

    // Watchdog timeout, motor silent
    do_reset();
    req = 2'b01;
    tick(); tick(); tick();                             // cycle 3: RUN entry
    cnt = 0;
    while (!stop && cnt < 1100) begin
      tick();
      cnt++;
    end
    check("timeout_latency", 64'(cnt), 64'd1000);
    tick();
    check("timeout_clear", 64'(clear_mt_success), 64'd1);
    tick();
    check("timeout_done", 64'(done), 64'd1);
    check("timeout_status", 64'(status), 64'd2);
    req = 2'b00;
    tick();

    // Reset in the middle of RUN (status still holds 2 from the timeout)
    req = 2'b01;
    tick(); tick(); tick();                             // RUN cycle 0
    for (int i = 0; i < 50; i++) tick();                // RUN cycle 50
    rst = 1'b1;
    #1;
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_status", 64'(status), 64'd0);
    check("midrst_pos", 64'(position_set), 64'd0);
    check("midrst_ctrl", 64'({start, stop, clear_mt_success, done}), 64'd0);
    req = 2'b00;
    tick();
    rst = 1'b0;
    req = 2'b10;
    fast_move(2'b10, "midrst_r1");
    check("midrst_r1_pos", 64'(position_set), 64'd5);
    req = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
